// File: rtl/prm_chk_pkg.sv
// Shared definitions for the edge-mask packer: geometry, state encoding and
// the word-to-bit-offset helper used by the staging register.
`default_nettype none

package prm_chk_pkg;

  localparam int DW     = 32;
  localparam int WORDS  = 128;
  localparam int MASK_W = DW * WORDS;
  localparam int BANK_W = 3;
  localparam int WORD_W = 4;
  localparam int PTR_W  = BANK_W + WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Bit offset of word k inside the mask ({bank, word} * 32).
  function automatic logic [PTR_W+4:0] word_base(input logic [PTR_W-1:0] k);
    return {k, 5'b0_0000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
`default_nettype none

module sat_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_mask_packer.sv
// Assembles a 128-word mask frame from a valid/ready stream and commits the
// full 4096-bit mask as a single-cycle strobe.
`default_nettype none

module edge_mask_packer #(
  parameter int DW    = 32,
  parameter int WORDS = 128,
  parameter int CNT_W = 16
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  input  logic                s_sof,
  input  logic                abort,
  output logic [DW*WORDS-1:0] edge_mask,
  output logic                mask_valid,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                sof_err
);

  import prm_chk_pkg::*;

  localparam int MASK_L = DW * WORDS;

  state_t              state;
  state_t              state_nxt;
  logic [PTR_W-1:0]    ptr;
  logic [MASK_L-1:0]   stage;
  logic                xfer;
  logic                last_word;
  logic                drop_inc;

  assign s_ready   = (state != COMMIT);
  assign xfer      = s_valid && s_ready;
  assign last_word = (ptr == PTR_W'(WORDS - 1));
  assign drop_inc  = (state == IDLE) && xfer && !s_sof && !abort;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort outranks any transfer, sof included; COMMIT ignores it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!abort && xfer && s_sof) state_nxt = FILL;
      end
      FILL: begin
        if (abort)                                state_nxt = IDLE;
        else if (xfer && !s_sof && last_word)     state_nxt = COMMIT;
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ptr        <= '0;
      stage      <= '0;
      edge_mask  <= '0;
      mask_valid <= 1'b0;
      sof_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      edge_mask  <= '0;
      mask_valid <= 1'b0;
      sof_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            stage <= '0;
            ptr   <= '0;
          end else if (xfer && s_sof) begin
            stage[DW-1:0] <= s_data;
            ptr           <= PTR_W'(1);
          end
        end
        FILL: begin
          if (abort) begin
            stage <= '0;
            ptr   <= '0;
          end else if (xfer && s_sof) begin
            stage   <= {{(MASK_L-DW){1'b0}}, s_data};
            ptr     <= PTR_W'(1);
            sof_err <= 1'b1;
          end else if (xfer) begin
            stage[word_base(ptr) +: DW] <= s_data;
            ptr <= last_word ? '0 : ptr + PTR_W'(1);
          end
        end
        COMMIT: begin
          edge_mask  <= stage;
          mask_valid <= 1'b1;
          stage      <= '0;
          frame_cnt  <= frame_cnt + CNT_W'(1);
        end
        default: begin
          stage <= '0;
          ptr   <= '0;
        end
      endcase
    end
  end

  sat_cnt #(
    .W (CNT_W)
  ) u_drop_cnt (
    .CLK (CLK),
    .clr (!RST_n),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule

`default_nettype wire
